// File: rtl/alu_pkg.sv
// Opcodes, handshake FSM encoding and the registered flag bundle of the ALU execute unit.
// Shared with the Controller so both sides decode aluControlCode identically.
package alu_pkg;

  localparam int CODE_W = 4;
  typedef logic [CODE_W-1:0] aluCode_t;

  localparam aluCode_t ALU_ASR  = 4'd1;
  localparam aluCode_t ALU_ADD  = 4'd2;
  localparam aluCode_t ALU_LSL  = 4'd3;
  localparam aluCode_t ALU_OR   = 4'd4;
  localparam aluCode_t ALU_NOR  = 4'd5;
  localparam aluCode_t ALU_AND  = 4'd6;
  localparam aluCode_t ALU_CBZ  = 4'd7;
  localparam aluCode_t ALU_XOR  = 4'd9;
  localparam aluCode_t ALU_SUB  = 4'd10;
  localparam aluCode_t ALU_LSR  = 4'd11;
  localparam aluCode_t ALU_NAND = 4'd12;
  localparam aluCode_t ALU_MOV  = 4'd13;
  localparam aluCode_t ALU_MUL  = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } aluState_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } aluFlags_t;

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, DATA_WIDTH steps.
// The multiplier sits in the low half of the accumulator and is consumed as it shifts out.
module mul_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      lastStep,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic [2*DATA_WIDTH-1:0]   productNext
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [CW-1:0]           count;
  logic                    busy;
  logic [DATA_WIDTH:0]     hiSum;
  logic [2*DATA_WIDTH:0]   stepVec;

  always_comb begin
    hiSum       = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} +
                  (acc[0] ? {1'b0, mcand} : '0);
    stepVec     = {hiSum, acc[DATA_WIDTH-1:0]};
    productNext = stepVec[2*DATA_WIDTH:1];
    lastStep    = busy && (count == CW'(DATA_WIDTH-1));
    product     = acc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc   <= '0;
      mcand <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      acc   <= {{DATA_WIDTH{1'b0}}, a};
      mcand <= b;
      count <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc   <= productNext;
      count <= count + 1'b1;
      if (lastStep) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: combinational op mux and flags, registered result/flags with a
// valid/ready handshake, and an FSM that stalls the input side while MUL iterates.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] readData1,
  input  logic [DATA_WIDTH-1:0] readData2,
  input  logic [CODE_WIDTH-1:0] aluControlCode,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zeroFlag,
  output logic                  negFlag,
  output logic                  carryBit,
  output logic                  overflowFlag,
  output logic                  illegalOp
);

  localparam int SHW = $clog2(DATA_WIDTH);

  aluState_t state, nextState;
  aluCode_t  op;
  aluFlags_t flagsQ, opFlags, mulFlags;

  logic [DATA_WIDTH-1:0]   opRes;
  logic [DATA_WIDTH:0]     addSum, subDiff;
  logic [SHW-1:0]          shAmt;
  logic                    outFree, accept, loadSingle, mulStart, loadMul, mulFromNext;
  logic                    lastStep;
  logic [2*DATA_WIDTH-1:0] product, productNext, mulProd;

  assign op       = aluCode_t'(aluControlCode);
  assign shAmt    = readData2[SHW-1:0];
  assign outFree  = !outValid || outReady;
  assign inReady  = (state == IDLE) && outFree;
  assign accept   = inValid && inReady;
  assign mulStart = accept && (op == ALU_MUL);
  assign loadSingle = accept && (op != ALU_MUL);

  always_comb begin
    addSum  = {1'b0, readData1} + {1'b0, readData2};
    subDiff = {1'b0, readData1} + {1'b0, ~readData2} + (DATA_WIDTH+1)'(1);
    opRes   = '0;
    opFlags = '0;
    case (op)
      ALU_ADD: begin
        opRes         = addSum[DATA_WIDTH-1:0];
        opFlags.carry = addSum[DATA_WIDTH];
        opFlags.ovf   = (readData1[DATA_WIDTH-1] == readData2[DATA_WIDTH-1]) &&
                        (addSum[DATA_WIDTH-1] != readData1[DATA_WIDTH-1]);
      end
      // carry out of A + ~B + 1 is the inverted borrow
      ALU_SUB: begin
        opRes         = subDiff[DATA_WIDTH-1:0];
        opFlags.carry = subDiff[DATA_WIDTH];
        opFlags.ovf   = (readData1[DATA_WIDTH-1] != readData2[DATA_WIDTH-1]) &&
                        (subDiff[DATA_WIDTH-1] != readData1[DATA_WIDTH-1]);
      end
      ALU_AND:  opRes = readData1 & readData2;
      ALU_OR:   opRes = readData1 | readData2;
      ALU_XOR:  opRes = readData1 ^ readData2;
      ALU_NOR:  opRes = ~(readData1 | readData2);
      ALU_NAND: opRes = ~(readData1 & readData2);
      ALU_MOV:  opRes = readData2;
      ALU_CBZ:  opRes = readData2;
      ALU_LSL:  opRes = readData1 << shAmt;
      ALU_LSR:  opRes = readData1 >> shAmt;
      ALU_ASR:  opRes = DATA_WIDTH'($signed(readData1) >>> shAmt);
      ALU_MUL:  opRes = '0;
      default:  opFlags.illegal = 1'b1;
    endcase
    opFlags.zero = opFlags.illegal || (opRes == '0);
    opFlags.neg  = opRes[DATA_WIDTH-1];
  end

  mul_iter #(.DATA_WIDTH(DATA_WIDTH)) uMul (
    .clock       (clock),
    .reset       (reset),
    .start       (mulStart),
    .a           (readData1),
    .b           (readData2),
    .lastStep    (lastStep),
    .product     (product),
    .productNext (productNext)
  );

  always_comb begin
    nextState   = state;
    loadMul     = 1'b0;
    mulFromNext = 1'b0;
    case (state)
      IDLE: if (mulStart) nextState = MUL;
      // the final step's sum goes straight into the output register when it is free
      MUL: if (lastStep) begin
        if (outFree) begin
          loadMul     = 1'b1;
          mulFromNext = 1'b1;
          nextState   = IDLE;
        end else begin
          nextState = HOLD;
        end
      end
      HOLD: if (outFree) begin
        loadMul   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    mulProd          = mulFromNext ? productNext : product;
    mulFlags         = '0;
    mulFlags.zero    = (mulProd[DATA_WIDTH-1:0] == '0);
    mulFlags.neg     = mulProd[DATA_WIDTH-1];
    mulFlags.carry   = |mulProd[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outValid <= 1'b0;
      result   <= '0;
      flagsQ   <= '0;
    end else if (loadSingle) begin
      outValid <= 1'b1;
      result   <= opRes;
      flagsQ   <= opFlags;
    end else if (loadMul) begin
      outValid <= 1'b1;
      result   <= mulProd[DATA_WIDTH-1:0];
      flagsQ   <= mulFlags;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

  assign zeroFlag     = flagsQ.zero;
  assign negFlag      = flagsQ.neg;
  assign carryBit     = flagsQ.carry;
  assign overflowFlag = flagsQ.ovf;
  assign illegalOp    = flagsQ.illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares each result the consumer takes.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] r;
    logic z, n, c, v, ill;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0, inReady;
  logic [31:0] readData1 = '0, readData2 = '0;
  logic [3:0]  aluControlCode = '0;
  logic        outValid, outReady = 1'b0;
  logic [31:0] result;
  logic        zeroFlag, negFlag, carryBit, overflowFlag, illegalOp;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  alu_exec_unit #(.DATA_WIDTH(32), .CODE_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .readData1(readData1), .readData2(readData2), .aluControlCode(aluControlCode),
    .outValid(outValid), .outReady(outReady), .result(result),
    .zeroFlag(zeroFlag), .negFlag(negFlag), .carryBit(carryBit),
    .overflowFlag(overflowFlag), .illegalOp(illegalOp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic z, n, c, v, ill);
    mk = '{r: r, z: z, n: n, c: c, v: v, ill: ill};
  endfunction

  // consumer side: every result taken must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && outValid && outReady) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {27'd0, result, zeroFlag, negFlag, carryBit, overflowFlag, illegalOp}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {27'd0, result, zeroFlag, negFlag, carryBit, overflowFlag, illegalOp},
            {27'd0, e});
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] code,
                      input exp_t e, input bit push);
    bit ok = 0;
    readData1 = a; readData2 = b; aluControlCode = code; inValid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (inReady) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    else if (push) sb.push_back(e);
    @(posedge clock); #1;
    inValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lowCnt;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_outValid", {63'd0, outValid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_flags", {59'd0, zeroFlag, negFlag, carryBit, overflowFlag, illegalOp}, 64'd0);
    chk("rst_inReady", {63'd0, inReady}, 64'd1);
    @(posedge clock); #1;
    outReady = 1'b1;

    // arithmetic and flags, issued back to back
    send(32'd15, 32'd15, 4'd2,  mk(32'd30,        0,0,0,0,0), 1);
    send(32'd10, 32'd15, 4'd10, mk(32'hFFFFFFFB,  0,1,0,0,0), 1);
    send(32'd15, 32'd15, 4'd10, mk(32'd0,         1,0,1,0,0), 1);
    send(32'd2140483647, 32'd2141483647, 4'd2, mk(32'hFF39A2BE, 0,1,0,1,0), 1);
    send(32'hFFFFFFFF, 32'd1, 4'd2, mk(32'd0,     1,0,1,0,0), 1);
    send(32'h80000000, 32'd1, 4'd10, mk(32'h7FFFFFFF, 0,0,1,1,0), 1);
    // logic, moves, shifts
    send(32'hF0F0, 32'hFF00, 4'd6,  mk(32'hF000,     0,0,0,0,0), 1);
    send(32'hF0F0, 32'h0F0F, 4'd4,  mk(32'hFFFF,     0,0,0,0,0), 1);
    send(32'hFF00, 32'h0FF0, 4'd9,  mk(32'hF0F0,     0,0,0,0,0), 1);
    send(32'd0,    32'd0,    4'd5,  mk(32'hFFFFFFFF, 0,1,0,0,0), 1);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12, mk(32'd0, 1,0,0,0,0), 1);
    send(32'd99,   32'h1234, 4'd13, mk(32'h1234,     0,0,0,0,0), 1);
    send(32'd7,    32'd0,    4'd7,  mk(32'd0,        1,0,0,0,0), 1);
    send(32'd7,    32'd5,    4'd7,  mk(32'd5,        0,0,0,0,0), 1);
    send(32'd1,    32'h21,   4'd3,  mk(32'd2,        0,0,0,0,0), 1);
    send(32'h80000000, 32'd31, 4'd11, mk(32'd1,      0,0,0,0,0), 1);
    send(32'h80000000, 32'd4,  4'd1,  mk(32'hF8000000, 0,1,0,0,0), 1);

    // MUL latency and input stall
    repeat (3) @(posedge clock); #1;
    send(32'd7, 32'd6, 4'd14, mk(32'd42, 0,0,0,0,0), 1);
    lat = 0; lowCnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (outValid) begin lat = k; break; end
      if (!inReady) lowCnt++;
    end
    chk("mul_latency", 64'(lat), 64'd33);
    chk("mul_stall_cycles", 64'(lowCnt), 64'd32);
    @(posedge clock); #1;
    send(32'h10000, 32'h10000, 4'd14, mk(32'd0, 1,0,1,0,0), 1);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd14, mk(32'd1, 0,0,1,0,0), 1);
    repeat (40) @(posedge clock); #1;

    // back-pressure: result held, then drain and refill on the same edge
    outReady = 1'b0;
    send(32'd5, 32'd15, 4'd6, mk(32'd5, 0,0,0,0,0), 1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("hold_outValid", {63'd0, outValid}, 64'd1);
    chk("hold_result", {32'd0, result}, 64'd5);
    chk("hold_inReady", {63'd0, inReady}, 64'd0);
    @(posedge clock); #1;
    outReady = 1'b1;
    send(32'd5, 32'd10, 4'd9, mk(32'd15, 0,0,0,0,0), 1);
    @(negedge clock);
    chk("no_bubble_outValid", {63'd0, outValid}, 64'd1);
    chk("no_bubble_result", {32'd0, result}, 64'd15);
    repeat (3) @(posedge clock); #1;

    // reset aborts a MUL in progress
    send(32'd3, 32'd3, 4'd14, mk(32'd9, 0,0,0,0,0), 0);
    repeat (9) @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_outValid", {63'd0, outValid}, 64'd0);
    chk("abort_inReady", {63'd0, inReady}, 64'd1);
    chk("abort_result", {32'd0, result}, 64'd0);
    lowCnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (outValid) lowCnt++;
    end
    chk("abort_no_output", 64'(lowCnt), 64'd0);
    @(posedge clock); #1;

    // unrecognised codes
    send(32'd123, 32'd456, 4'd15, mk(32'd0, 1,0,0,0,1), 1);
    send(32'd1,   32'd1,   4'd0,  mk(32'd0, 1,0,0,0,1), 1);
    send(32'd1,   32'd1,   4'd2,  mk(32'd2, 0,0,0,0,0), 1);

    repeat (5) @(posedge clock);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
